ddr_burst_datapath: RTL
=======================

DDR_BURST_DATAPATH -- requirements
Module: ddr_burst_datapath

Interface
REQ-001 Parameter DQ_W, default 16: DQ bus width in bits; a multiple of 8.
REQ-002 Parameter BL, default 8: burst length in beats; even, 2..16.
REQ-003 Parameter WL, default 1: write latency in clk cycles from command accept to first data cycle; 1..7.
REQ-004 Parameter RL, default 3: read latency in clk cycles from command accept to first capture cycle; 1..15.
REQ-005 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst_n, in, 1: async active-low reset.
- cmd_valid, in, 1: command request.
- cmd_we, in, 1: 1 = write, 0 = read.
- cmd_ready, out, 1: command accepted when high with cmd_valid.
- wr_data, in, DQ_W*BL: write burst word; beat 0 in the MSBs.
- wr_mask, in, DQ_W/8*BL: byte masks, beat 0 in the MSBs.
- dq_rise_o / dq_fall_o, out, DQ_W: beats launched on the clk rise / fall edge.
- dm_rise_o / dm_fall_o, out, DQ_W/8: per-beat byte masks.
- dq_oe, out, 1: DQ drive enable.
- dqs_oe, out, 1: DQS drive enable.
- dq_rise_i / dq_fall_i, in, DQ_W: beats captured by the IO cells.
- rd_data, out, DQ_W*BL: assembled read burst.
- rd_valid, out, 1: rd_data valid, one-cycle pulse.

Function
REQ-007 FSM states SHALL be IDLE, WR_LAT, WR_BURST, RD_LAT, RD_BURST; cmd_ready SHALL equal (state==IDLE) combinationally.
REQ-008 Accept (cmd_valid & cmd_ready) SHALL register wr_data/wr_mask when cmd_we=1 and enter WR_LAT, else enter RD_LAT; latency counter cleared.
REQ-009 WR_LAT SHALL last exactly WL cycles, then WR_BURST; RD_LAT SHALL last exactly RL cycles, then RD_BURST.
REQ-010 WR_BURST and RD_BURST SHALL each last exactly BL/2 cycles, then return to IDLE; a new command is acceptable the cycle IDLE is re-entered.
REQ-011 In WR_BURST cycle k (0..BL/2-1), dq_rise_o SHALL carry beat 2k and dq_fall_o beat 2k+1, registered; beat n = wr_data[DQ_W*(BL-n)-1 -: DQ_W].
REQ-012 dq_oe SHALL be high exactly during WR_BURST cycles.
REQ-013 dqs_oe SHALL be high during the last WR_LAT cycle (preamble) and all WR_BURST cycles.
REQ-014 Outside WR_BURST, dq_*_o SHALL hold 0.
REQ-015 In RD_BURST cycle k, dq_rise_i SHALL be stored as beat 2k and dq_fall_i as beat 2k+1 of an internal shift/assembly register.
REQ-016 rd_valid SHALL pulse high the cycle after the last RD_BURST cycle, with rd_data holding the full burst; rd_data SHALL hold that value until the next rd_valid.
REQ-017 Read-command-accept-to-rd_valid latency SHALL be RL+BL/2+1 cycles; write-accept-to-first-dq_oe latency SHALL be WL+1 cycles.
REQ-018 cmd_valid in any non-IDLE state SHALL be ignored and SHALL NOT corrupt the latched write word.

Reset
REQ-019 rst_n low SHALL asynchronously force: state IDLE, counters 0, dq_oe=0, dqs_oe=0, rd_valid=0, dq_*_o=0, dm_*_o=0, rd_data=0.
REQ-020 Reset mid-burst SHALL abort the burst without a rd_valid pulse; after release, cmd_ready=1 on the first clk edge.

Configuration
REQ-021 With DDR_DM_EN defined, dm_rise_o/dm_fall_o SHALL carry wr_mask beats 2k/2k+1 in WR_BURST with identical timing to DQ, and 0 otherwise.
REQ-022 Without DDR_DM_EN, wr_mask SHALL be ignored, and dm_*_o SHALL be constant 0 with no mask register synthesised.

Structure
REQ-023 Package ddr_pkg SHALL hold the FSM state encoding and beat-index helper constants.
REQ-024 Sub-module ddr_beat_sel SHALL implement a combinational mux selecting beat pair k from a DQ_W*BL word; it is used by the write path.

Verification
REQ-025 Defaults, write wr_data=128'h0001_0002_..._0008 -> dq_oe is high for cycles 2..5 after accept; rise/fall pairs are (0001,0002), (0003,0004), (0005,0006), (0007,0008).
REQ-026 Defaults, read with dq_rise_i/dq_fall_i driven as the same pairs -> rd_valid pulses 8 cycles after accept; rd_data=128'h0001_..._0008.
REQ-027 Back-to-back write then read with cmd_valid held high -> the read is accepted on the IDLE cycle after the write burst, and no beat is lost.
REQ-028 rst_n pulled low during RD_BURST cycle 2 -> all outputs are 0 immediately, no rd_valid pulse follows, and cmd_ready=1 after release.
REQ-029 DDR_DM_EN defined, wr_mask=16'hC000 -> dm_rise_o=2'b11 in burst cycle 0 only; without the macro, dm outputs stay 0.
REQ-030 BL=4, DQ_W=32, WL=2, RL=5 -> burst lasts 2 cycles and read latency is 8 cycles.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR burst datapath: FSM state encoding,
// counter width and helpers that locate a beat inside a packed burst word.
package ddr_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_LAT   = 3'd1,
    WR_BURST = 3'd2,
    RD_LAT   = 3'd3,
    RD_BURST = 3'd4
  } state_t;

  // Wide enough for the longest latency phase (RL up to 15) and BL/2 up to 8.
  localparam int CNT_W = 4;

  // Top bit index of beat n in a word of bl beats, each w bits wide.
  // Beat 0 sits in the MSBs.
  function automatic int beat_hi(input int w, input int bl, input int n);
    return w * (bl - n) - 1;
  endfunction

  // Bottom bit index of beat n, same packing as beat_hi.
  function automatic int beat_lo(input int w, input int bl, input int n);
    return w * (bl - n - 1);
  endfunction

endpackage

// File: rtl/ddr_burst_datapath_beat_sel.sv
// ddr_beat_sel: combinational mux picking beat pair k (beats 2k and 2k+1)
// out of a packed burst word. The write path uses one for DQ and, when
// masks are enabled, another for DM.
module ddr_beat_sel
  import ddr_pkg::*;
#(
  parameter int BEAT_W = 16,
  parameter int BL     = 8
) (
  input  logic [BEAT_W*BL-1:0] word,
  input  logic [CNT_W-1:0]     pair,
  output logic [BEAT_W-1:0]    rise,
  output logic [BEAT_W-1:0]    fall
);

  // Select the even beat for the rising edge and the odd beat for the falling edge.
  always_comb begin
    rise = '0;
    fall = '0;
    for (int k = 0; k < BL / 2; k++) begin
      if (pair == CNT_W'(k)) begin
        rise = word[beat_hi(BEAT_W, BL, 2 * k) -: BEAT_W];
        fall = word[beat_hi(BEAT_W, BL, 2 * k + 1) -: BEAT_W];
      end
    end
  end

endmodule

// File: rtl/ddr_burst_datapath.sv
// ddr_burst_datapath: command FSM plus write serialiser and read assembler
// for a DDR-style burst interface. All DQ/DQS/DM outputs are registered.
// Optional feature: define DDR_DM_EN to drive per-beat byte masks on
// dm_rise_o/dm_fall_o; without it the mask input is ignored and no mask
// register exists.
module ddr_burst_datapath
  import ddr_pkg::*;
#(
  parameter int DQ_W = 16,
  parameter int BL   = 8,
  parameter int WL   = 1,
  parameter int RL   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic                   cmd_we,
  output logic                   cmd_ready,
  input  logic [DQ_W*BL-1:0]     wr_data,
  input  logic [DQ_W/8*BL-1:0]   wr_mask,
  output logic [DQ_W-1:0]        dq_rise_o,
  output logic [DQ_W-1:0]        dq_fall_o,
  output logic [DQ_W/8-1:0]      dm_rise_o,
  output logic [DQ_W/8-1:0]      dm_fall_o,
  output logic                   dq_oe,
  output logic                   dqs_oe,
  input  logic [DQ_W-1:0]        dq_rise_i,
  input  logic [DQ_W-1:0]        dq_fall_i,
  output logic [DQ_W*BL-1:0]     rd_data,
  output logic                   rd_valid
);

  localparam int WORD_W = DQ_W * BL;
  localparam int MB     = DQ_W / 8;

  localparam logic [CNT_W-1:0] WL_LAST    = CNT_W'(WL - 1);
  localparam logic [CNT_W-1:0] RL_LAST    = CNT_W'(RL - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BL / 2 - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   next_cnt;
  logic               accept;
  logic               last_rd_beat;

  logic [WORD_W-1:0]  wr_word;
  logic [DQ_W-1:0]    sel_rise;
  logic [DQ_W-1:0]    sel_fall;

  logic [WORD_W-1:0]  asm_reg;
  logic [WORD_W-1:0]  asm_next;

  assign cmd_ready    = (state == IDLE);
  assign accept       = cmd_valid && cmd_ready;
  assign last_rd_beat = (state == RD_BURST) && (cnt == BURST_LAST);

  // State and phase counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic: each phase runs its counter to a fixed last value.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          next_state = cmd_we ? WR_LAT : RD_LAT;
          next_cnt   = '0;
        end
      end
      WR_LAT: begin
        if (cnt == WL_LAST) begin
          next_state = WR_BURST;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      WR_BURST: begin
        if (cnt == BURST_LAST) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      RD_LAT: begin
        if (cnt == RL_LAST) begin
          next_state = RD_BURST;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      RD_BURST: begin
        if (cnt == BURST_LAST) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Latch the write word only on an accepted write, so busy-time traffic cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_word <= '0;
    end else if (accept && cmd_we) begin
      wr_word <= wr_data;
    end
  end

  // The mux is indexed by the next counter value so the registered outputs line up with the burst cycle.
  ddr_beat_sel #(
    .BEAT_W (DQ_W),
    .BL     (BL)
  ) u_dq_sel (
    .word (wr_word),
    .pair (next_cnt),
    .rise (sel_rise),
    .fall (sel_fall)
  );

  // Registered DQ launch and drive enables; DQS gets one preamble cycle ahead of DQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_oe     <= 1'b0;
      dqs_oe    <= 1'b0;
      dq_rise_o <= '0;
      dq_fall_o <= '0;
    end else begin
      dq_oe  <= (next_state == WR_BURST);
      dqs_oe <= (next_state == WR_BURST) ||
                ((next_state == WR_LAT) && (next_cnt == WL_LAST));
      if (next_state == WR_BURST) begin
        dq_rise_o <= sel_rise;
        dq_fall_o <= sel_fall;
      end else begin
        dq_rise_o <= '0;
        dq_fall_o <= '0;
      end
    end
  end

`ifdef DDR_DM_EN
  logic [MB*BL-1:0] mask_word;
  logic [MB-1:0]    mask_rise;
  logic [MB-1:0]    mask_fall;

  // Mask word is captured alongside the write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_word <= '0;
    end else if (accept && cmd_we) begin
      mask_word <= wr_mask;
    end
  end

  ddr_beat_sel #(
    .BEAT_W (MB),
    .BL     (BL)
  ) u_dm_sel (
    .word (mask_word),
    .pair (next_cnt),
    .rise (mask_rise),
    .fall (mask_fall)
  );

  // Mask beats follow exactly the same timing as the DQ beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_rise_o <= '0;
      dm_fall_o <= '0;
    end else if (next_state == WR_BURST) begin
      dm_rise_o <= mask_rise;
      dm_fall_o <= mask_fall;
    end else begin
      dm_rise_o <= '0;
      dm_fall_o <= '0;
    end
  end
`else
  logic unused_mask;

  assign unused_mask = ^wr_mask;
  assign dm_rise_o   = '0;
  assign dm_fall_o   = '0;
`endif

  // Drop the captured beat pair for the current burst cycle into its slot.
  always_comb begin
    asm_next = asm_reg;
    for (int k = 0; k < BL / 2; k++) begin
      if (cnt == CNT_W'(k)) begin
        asm_next[beat_hi(DQ_W, BL, 2 * k) -: DQ_W]     = dq_rise_i;
        asm_next[beat_hi(DQ_W, BL, 2 * k + 1) -: DQ_W] = dq_fall_i;
      end
    end
  end

  // Read assembly; the full word is published with a one-cycle valid pulse after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_reg  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= last_rd_beat;
      if (state == RD_BURST) begin
        asm_reg <= asm_next;
      end
      if (last_rd_beat) begin
        rd_data <= asm_next;
      end
    end
  end

endmodule
